// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package data_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned CNT_W      = 4;

   // Flags a byte address that is not word aligned or lies beyond the array.
   function automatic logic addr_error(input logic [31:0] addr, input int unsigned addr_width);
      logic [31:0] upper;
      upper = addr >> (addr_width + 2);
      return (addr[1:0] != 2'b00) || (upper != 32'd0);
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port word array: byte-lane write enables and a registered read.
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic [ADDR_WIDTH-1:0] index,
   input  logic [WORD_BYTES-1:0] wr_be,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  rd_en,
   output logic [DATA_W-1:0]     rd_data
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge CLK) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
         if (wr_be[i]) begin
            mem[index][8*i +: 8] <= wr_data[8*i +: 8];
         end
      end
      if (rd_en) begin
         rd_data <= mem[index];
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data port: valid/ready requests answered
// after a fixed LATENCY, with alignment and range checking.
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LATENCY    = 3
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  Req_valid,
   output logic                  Req_ready,
   input  logic                  Req_write,
   input  logic [31:0]           Req_address,
   input  logic [DATA_W-1:0]     Req_wdata,
   input  logic [WORD_BYTES-1:0] Req_byte_en,
   output logic                  Resp_valid,
   input  logic                  Resp_ready,
   output logic [DATA_W-1:0]     Resp_rdata,
   output logic                  Resp_error
);

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    valid_q, valid_d;
   logic [DATA_W-1:0]       rdata_q, rdata_d;
   logic                    error_q, error_d;
   logic                    write_q, write_d;
   logic                    bad_q, bad_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [WORD_BYTES-1:0]   be_q, be_d;

   logic [ADDR_WIDTH-1:0]   arr_index;
   logic [WORD_BYTES-1:0]   arr_be;
   logic [DATA_W-1:0]       arr_rdata;

   // Reading the incoming index while idle lets LATENCY=1 still see the word in time.
   assign arr_index = (state_q == IDLE) ? Req_address[ADDR_WIDTH+1:2] : idx_q;

   data_mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .CLK     (CLK),
      .index   (arr_index),
      .wr_be   (arr_be),
      .wr_data (wdata_q),
      .rd_en   (state_q != RESP),
      .rd_data (arr_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      valid_d = valid_q;
      rdata_d = rdata_q;
      error_d = error_q;
      write_d = write_q;
      bad_d   = bad_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      arr_be  = '0;

      case (state_q)
         IDLE: begin
            if (Req_valid && ready_q) begin
               write_d = Req_write;
               bad_d   = addr_error(Req_address, ADDR_WIDTH);
               idx_d   = Req_address[ADDR_WIDTH+1:2];
               wdata_d = Req_wdata;
               be_d    = Req_byte_en;
               cnt_d   = CNT_W'(LATENCY - 1);
               ready_d = 1'b0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               if (write_q && !bad_q) begin
                  arr_be = be_q;
               end
               rdata_d = (!write_q && !bad_q) ? arr_rdata : '0;
               error_d = bad_q;
               valid_d = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (Resp_ready) begin
               valid_d = 1'b0;
               rdata_d = '0;
               error_d = 1'b0;
               ready_d = 1'b1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         rdata_q <= '0;
         error_q <= 1'b0;
         write_q <= 1'b0;
         bad_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         be_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         write_q <= write_d;
         bad_q   <= bad_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
      end
   end

   assign Req_ready  = ready_q;
   assign Resp_valid = valid_q;
   assign Resp_rdata = rdata_q;
   assign Resp_error = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder at LATENCY=3 and LATENCY=1.
module tb_data_mem_responder;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        sel = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_address = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        resp_ready = 1'b0;

   logic        r3_ready, r3_valid, r3_error, r1_ready, r1_valid, r1_error;
   logic [31:0] r3_rdata, r1_rdata;
   logic        req_ready, resp_valid, resp_error;
   logic [31:0] resp_rdata;

   exp_t        sb[$];
   logic [31:0] model [2][256];
   int          n_checks = 0;
   int          n_pass = 0;

   always #5 CLK = ~CLK;

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) dut3 (
      .CLK(CLK), .RESET(RESET),
      .Req_valid(req_valid & ~sel), .Req_ready(r3_ready), .Req_write(req_write),
      .Req_address(req_address), .Req_wdata(req_wdata), .Req_byte_en(req_be),
      .Resp_valid(r3_valid), .Resp_ready(resp_ready & ~sel),
      .Resp_rdata(r3_rdata), .Resp_error(r3_error)
   );

   data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(1)) dut1 (
      .CLK(CLK), .RESET(RESET),
      .Req_valid(req_valid & sel), .Req_ready(r1_ready), .Req_write(req_write),
      .Req_address(req_address), .Req_wdata(req_wdata), .Req_byte_en(req_be),
      .Resp_valid(r1_valid), .Resp_ready(resp_ready & sel),
      .Resp_rdata(r1_rdata), .Resp_error(r1_error)
   );

   assign req_ready  = sel ? r1_ready : r3_ready;
   assign resp_valid = sel ? r1_valid : r3_valid;
   assign resp_rdata = sel ? r1_rdata : r3_rdata;
   assign resp_error = sel ? r1_error : r3_error;

   // Drives one request starting at a negedge; returns at the negedge after acceptance.
   task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input bit track);
      logic       e;
      logic [7:0] idx;
      int         n;
      int         s;
      exp_t       x;
      s   = sel ? 1 : 0;
      e   = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
      idx = a[9:2];
      req_write = w; req_address = a; req_wdata = d; req_be = be; req_valid = 1'b1;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL accept_timeout addr=%h ready=%b want 1", a, req_ready);
      else n_pass++;
      @(posedge CLK);
      @(negedge CLK);
      req_valid = 1'b0;
      if (track) begin
         x.err   = e;
         x.rdata = (!w && !e) ? model[s][idx] : 32'd0;
         sb.push_back(x);
         if (w && !e)
            for (int i = 0; i < 4; i++)
               if (be[i]) model[s][idx][8*i +: 8] = d[8*i +: 8];
      end
   endtask

   task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 40) begin
         @(negedge CLK);
         lat++;
      end
      if (resp_valid !== 1'b1) lat = -1;
      rd = resp_rdata;
      er = resp_error;
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge CLK);
      n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", req_ready); else n_pass++;
      n_checks++; if (resp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", resp_valid); else n_pass++;
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++; if (resp_rdata !== 32'd0) $display("FAIL rst_rdata got %h want 0", resp_rdata); else n_pass++;
      n_checks++; if (resp_error !== 1'b0) $display("FAIL rst_error got %b want 0", resp_error); else n_pass++;
   endtask

   // Issues a list of requests and checks each response against the scoreboard.
   task automatic run_list(input string name, input logic w [], input logic [31:0] a [],
                           input logic [31:0] d [], input logic [3:0] be [], input int exp_lat);
      int          lat;
      logic [31:0] rd;
      logic        er;
      exp_t        x;
      for (int k = 0; k < a.size(); k++) begin
         send(w[k], a[k], d[k], be[k], 1'b1);
         n_checks++;
         if (req_ready !== 1'b0) $display("FAIL %s_ready_drop[%0d] got %b want 0", name, k, req_ready);
         else n_pass++;
         wait_resp(lat, rd, er);
         x = sb.pop_front();
         n_checks++; if (lat != exp_lat) $display("FAIL %s_latency[%0d] got %0d want %0d", name, k, lat, exp_lat); else n_pass++;
         n_checks++; if (rd !== x.rdata) $display("FAIL %s_rdata[%0d] got %h want %h", name, k, rd, x.rdata); else n_pass++;
         n_checks++; if (er !== x.err) $display("FAIL %s_error[%0d] got %b want %b", name, k, er, x.err); else n_pass++;
         consume();
         n_checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL %s_release[%0d] valid=%b ready=%b want 0/1", name, k, resp_valid, req_ready);
         else n_pass++;
      end
   endtask

   task automatic test_store();
      run_list("store", '{1'b1}, '{32'h10}, '{32'hDEADBEEF}, '{4'b1111}, 3);
   endtask

   task automatic test_load_partial();
      run_list("partial", '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
               '{32'h10, 32'h10, 32'h10, 32'h10, 32'h10},
               '{32'h0, 32'h11223344, 32'h0, 32'hFFFFFFFF, 32'h0},
               '{4'b0000, 4'b0101, 4'b0000, 4'b0000, 4'b1111}, 3);
   endtask

   task automatic test_errors();
      run_list("errors", '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0},
               '{32'h12, 32'h400, 32'h11, 32'h410, 32'h10},
               '{32'h0, 32'h0, 32'h99999999, 32'h77777777, 32'h0},
               '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111}, 3);
   endtask

   task automatic test_backpressure();
      int          lat;
      logic [31:0] rd;
      logic        er;
      exp_t        x;
      run_list("bp_setup", '{1'b1}, '{32'h20}, '{32'h55AA55AA}, '{4'b1111}, 3);
      send(1'b0, 32'h10, 32'h0, 4'b0000, 1'b1);
      wait_resp(lat, rd, er);
      x = sb.pop_front();
      n_checks++; if (rd !== x.rdata) $display("FAIL bp_rdata got %h want %h", rd, x.rdata); else n_pass++;
      req_write = 1'b1; req_address = 32'h20; req_wdata = 32'h0BADBEEF; req_be = 4'b1111;
      req_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         n_checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== x.rdata || resp_error !== x.err || req_ready !== 1'b0)
            $display("FAIL bp_hold[%0d] valid=%b rdata=%h err=%b ready=%b want 1/%h/%b/0",
                     k, resp_valid, resp_rdata, resp_error, req_ready, x.rdata, x.err);
         else n_pass++;
      end
      req_valid = 1'b0;
      consume();
      run_list("bp_check", '{1'b0}, '{32'h20}, '{32'h0}, '{4'b0000}, 3);
   endtask

   task automatic test_reset_mid();
      run_list("rm_setup", '{1'b1}, '{32'h30}, '{32'h01020304}, '{4'b1111}, 3);
      send(1'b1, 32'h30, 32'hFFFFFFFF, 4'b1111, 1'b0);
      @(posedge CLK);
      #2 RESET = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_error !== 1'b0)
         $display("FAIL rm_async ready=%b valid=%b rdata=%h err=%b want 1/0/0/0",
                  req_ready, resp_valid, resp_rdata, resp_error);
      else n_pass++;
      @(negedge CLK);
      RESET = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      n_checks++; if (req_ready !== 1'b1) $display("FAIL rm_ready got %b want 1", req_ready); else n_pass++;
      run_list("rm_check", '{1'b0}, '{32'h30}, '{32'h0}, '{4'b0000}, 3);
   endtask

   task automatic test_back_to_back();
      run_list("b2b_l3", '{1'b1, 1'b0}, '{32'h40, 32'h40}, '{32'hCAFEF00D, 32'h0},
               '{4'b1111, 4'b0000}, 3);
      sel = 1'b1;
      @(negedge CLK);
      run_list("b2b_l1", '{1'b1, 1'b0, 1'b1, 1'b0}, '{32'h40, 32'h40, 32'h44, 32'h44},
               '{32'hCAFEF00D, 32'h0, 32'h13579BDF, 32'h0},
               '{4'b1111, 4'b0000, 4'b1010, 4'b0000}, 1);
   endtask

   initial begin
      test_reset();
      test_store();
      test_load_partial();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
